// File: rtl/tube_display_sched.sv
// tube_display_sched
//
// Shares the 4-digit tube display between an always-present base source and
// two timed message channels. Channel 2 preempts channel 1, and channel 1
// preempts the base. Each accepted message stays on the display for
// HOLD_CYCLES displayed cycles. A preempted channel 1 keeps its remaining
// count and resumes when channel 2 finishes. Each digit can blink.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   base_digits  base digits; [3:0]->in1, [7:4]->in2, [11:8]->in3, [15:12]->in4
//   base_dp      base decimal points; bit i -> dp[i]
//   base_blink   per-digit blink enable for the base
//   msg_valid    per-channel request; bit k = channel k+1
//   msg_ready    per-channel slot empty
//   msg_digits   channel k digits in [16k+15:16k], same mapping as base_digits
//   msg_dp       channel k decimal points in [4k+3:4k]
//   msg_blink    channel k blink enables in [4k+3:4k]
//   msg_cancel   per-channel cancel; ignored when the slot is empty
//   in1..in4     registered digit codes to the display driver
//   dp           registered decimal points to the display driver
//   active_src   registered source on the outputs: 0 base, 1 ch1, 2 ch2
module tube_display_sched #(
  parameter int          HOLD_W      = 28,
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter int          BLINK_W     = 24,
  parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] base_digits,
  input  logic [3:0]  base_dp,
  input  logic [3:0]  base_blink,
  input  logic [1:0]  msg_valid,
  output logic [1:0]  msg_ready,
  input  logic [31:0] msg_digits,
  input  logic [7:0]  msg_dp,
  input  logic [7:0]  msg_blink,
  input  logic [1:0]  msg_cancel,
  output logic [3:0]  in1,
  output logic [3:0]  in2,
  output logic [3:0]  in3,
  output logic [3:0]  in4,
  output logic [3:0]  dp,
  output logic [1:0]  active_src
);

  // The timer holds the number of displayed cycles still owed after the
  // current one, so a slot is cleared at the edge where it reads zero.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  // Per-channel slot state
  logic [1:0]             full_q,   full_d;
  logic [1:0][HOLD_W-1:0] timer_q,  timer_d;
  logic [1:0][15:0]       digits_q, digits_d;
  logic [1:0][3:0]        sdp_q,    sdp_d;
  logic [1:0][3:0]        blink_q,  blink_d;

  // Free-running blink counter; its MSB is the blink phase
  logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;

  // Output registers
  logic [15:0]            out_digits_q, out_digits_d;
  logic [3:0]             out_dp_q,     out_dp_d;
  logic [1:0]             src_q,        src_d;

  // Selection and blink-masked source, all from current slot state
  logic [1:0]             sel;
  logic [15:0]            src_digits;
  logic [3:0]             src_dp;
  logic [3:0]             src_blink;
  logic                   blink_phase;

  always_comb begin
    sel         = 2'd0;
    src_digits  = base_digits;
    src_dp      = base_dp;
    src_blink   = base_blink;
    blink_phase = blink_cnt_q[BLINK_W-1];

    if (full_q[1]) begin
      sel        = 2'd2;
      src_digits = digits_q[1];
      src_dp     = sdp_q[1];
      src_blink  = blink_q[1];
    end else if (full_q[0]) begin
      sel        = 2'd1;
      src_digits = digits_q[0];
      src_dp     = sdp_q[0];
      src_blink  = blink_q[0];
    end

    out_digits_d = src_digits;
    out_dp_d     = src_dp;
    for (int i = 0; i < 4; i++) begin
      if (blink_phase && src_blink[i]) begin
        out_digits_d[4*i +: 4] = BLANK_CODE;
        out_dp_d[i]            = 1'b0;
      end
    end
    src_d       = sel;
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
  end

  // Slot update. Accept only happens into an empty slot, so it can never
  // collide with cancel or expiry of the same slot.
  always_comb begin
    full_d   = full_q;
    timer_d  = timer_q;
    digits_d = digits_q;
    sdp_d    = sdp_q;
    blink_d  = blink_q;

    for (int k = 0; k < 2; k++) begin
      if (full_q[k]) begin
        if (msg_cancel[k]) begin
          full_d[k] = 1'b0;
        end else if (sel == 2'(k + 1)) begin
          // Only the channel on display consumes its hold time
          if (timer_q[k] == '0) begin
            full_d[k] = 1'b0;
          end else begin
            timer_d[k] = timer_q[k] - HOLD_W'(1);
          end
        end
      end else if (msg_valid[k]) begin
        full_d[k]   = 1'b1;
        timer_d[k]  = HOLD_LOAD;
        digits_d[k] = msg_digits[16*k +: 16];
        sdp_d[k]    = msg_dp[4*k +: 4];
        blink_d[k]  = msg_blink[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= '0;
      timer_q      <= '0;
      digits_q     <= '0;
      sdp_q        <= '0;
      blink_q      <= '0;
      blink_cnt_q  <= '0;
      out_digits_q <= {4{BLANK_CODE}};
      out_dp_q     <= '0;
      src_q        <= 2'd0;
    end else begin
      full_q       <= full_d;
      timer_q      <= timer_d;
      digits_q     <= digits_d;
      sdp_q        <= sdp_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      out_digits_q <= out_digits_d;
      out_dp_q     <= out_dp_d;
      src_q        <= src_d;
    end
  end

  assign msg_ready  = ~full_q;
  assign in1        = out_digits_q[3:0];
  assign in2        = out_digits_q[7:4];
  assign in3        = out_digits_q[11:8];
  assign in4        = out_digits_q[15:12];
  assign dp         = out_dp_q;
  assign active_src = src_q;

endmodule

// File: tb/tb_tube_display_sched.sv
// Testbench for tube_display_sched. A behavioural model tracks, per channel,
// how many displayed cycles remain; it is stepped at every clock edge with
// the same inputs the DUT sees and compared against the DUT outputs.
module tb_tube_display_sched;

  localparam int         HOLD_W      = 8;
  localparam int         HOLD_CYCLES = 5;
  localparam int         BLINK_W     = 3;
  localparam logic [3:0] BLANK       = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] base_digits = 16'h1234;
  logic [3:0]  base_dp = 4'h0;
  logic [3:0]  base_blink = 4'h0;
  logic [1:0]  msg_valid = 2'b00;
  logic [1:0]  msg_ready;
  logic [31:0] msg_digits = 32'h0;
  logic [7:0]  msg_dp = 8'h0;
  logic [7:0]  msg_blink = 8'h0;
  logic [1:0]  msg_cancel = 2'b00;
  logic [3:0]  in1, in2, in3, in4, dp;
  logic [1:0]  active_src;

  tube_display_sched #(
    .HOLD_W(HOLD_W), .HOLD_CYCLES(HOLD_CYCLES), .BLINK_W(BLINK_W), .BLANK_CODE(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .base_digits(base_digits), .base_dp(base_dp), .base_blink(base_blink),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_digits(msg_digits), .msg_dp(msg_dp), .msg_blink(msg_blink),
    .msg_cancel(msg_cancel),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .dp(dp), .active_src(active_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [15:0] m_dig [2];
  logic [3:0]  m_dpv [2];
  logic [3:0]  m_blk [2];
  bit          m_full[2];
  int          m_rem [2];   // displayed cycles still to show
  logic [15:0] m_out;
  logic [3:0]  m_outdp;
  logic [1:0]  m_src;
  int          m_cyc;       // edges since reset release

  logic [23:0] obs;
  assign obs = {in4, in3, in2, in1, dp, active_src, msg_ready};

  function automatic logic [23:0] expected();
    return {m_out, m_outdp, m_src, ~m_full[1], ~m_full[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0; m_rem[k] = 0; m_dig[k] = '0; m_dpv[k] = '0; m_blk[k] = '0;
    end
    m_out = {4{BLANK}}; m_outdp = 4'h0; m_src = 2'd0; m_cyc = 0;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at it.
  task automatic step();
    int sel;
    bit phase;
    logic [15:0] sd;
    logic [3:0]  sp, sb;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      sel   = m_full[1] ? 2 : (m_full[0] ? 1 : 0);
      phase = (m_cyc % (1 << BLINK_W)) >= (1 << (BLINK_W - 1));
      if (sel == 0) begin
        sd = base_digits; sp = base_dp; sb = base_blink;
      end else begin
        sd = m_dig[sel-1]; sp = m_dpv[sel-1]; sb = m_blk[sel-1];
      end
      for (int i = 0; i < 4; i++) begin
        if (phase && sb[i]) begin
          sd[4*i +: 4] = BLANK;
          sp[i] = 1'b0;
        end
      end
      m_out = sd; m_outdp = sp; m_src = 2'(sel);
      for (int k = 0; k < 2; k++) begin
        if (m_full[k]) begin
          if (msg_cancel[k]) m_full[k] = 0;
          else if (sel == k + 1) begin
            m_rem[k]--;
            if (m_rem[k] == 0) m_full[k] = 0;
          end
        end else if (msg_valid[k]) begin
          m_full[k] = 1;
          m_rem[k]  = HOLD_CYCLES;
          m_dig[k]  = msg_digits[16*k +: 16];
          m_dpv[k]  = msg_dp[4*k +: 4];
          m_blk[k]  = msg_blink[4*k +: 4];
        end
      end
      m_cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    base_digits = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs !== {16'hFFFF, 4'h0, 2'd0, 2'b11}) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: got %h, expected %h", c, obs, {16'hFFFF, 4'h0, 2'd0, 2'b11});
      end
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (obs !== {16'h1234, 4'h0, 2'd0, 2'b11}) begin
      errors++;
      $display("FAIL reset_release: got %h, expected %h", obs, {16'h1234, 4'h0, 2'd0, 2'b11});
    end
  endtask

  task automatic test_single();
    int shown = 0, not_ready = 0;
    msg_digits[15:0] = 16'h5678;
    msg_valid = 2'b01;
    step();
    msg_valid = 2'b00;
    if (msg_ready[0] === 1'b0) not_ready++;
    for (int c = 0; c < 9; c++) begin
      step();
      if (active_src == 2'd1 && {in4, in3, in2, in1} == 16'h5678) shown++;
      if (msg_ready[0] === 1'b0) not_ready++;
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL single cyc=%0d: got %h, expected %h", c, obs, expected());
      end
    end
    checks++;
    if (shown != HOLD_CYCLES) begin
      errors++;
      $display("FAIL single_len: got %0d cycles shown, expected %0d", shown, HOLD_CYCLES);
    end
    checks++;
    if (not_ready != HOLD_CYCLES) begin
      errors++;
      $display("FAIL single_ready: got %0d not-ready cycles, expected %0d", not_ready, HOLD_CYCLES);
    end
  endtask

  task automatic test_preempt();
    int ch1_shown = 0, ch2_shown = 0;
    msg_digits = {16'hABCD, 16'h1111};
    msg_valid = 2'b01;
    step();
    msg_valid = 2'b00;
    step();                       // ch1 displayed cycle 1
    msg_valid = 2'b10;
    step();                       // ch1 displayed cycle 2, ch2 accepted
    msg_valid = 2'b00;
    ch1_shown = 2;
    for (int c = 0; c < 12; c++) begin
      step();
      if (active_src == 2'd1) ch1_shown++;
      if (active_src == 2'd2) ch2_shown++;
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL preempt cyc=%0d: got %h, expected %h", c, obs, expected());
      end
    end
    checks++;
    if (ch1_shown != HOLD_CYCLES || ch2_shown != HOLD_CYCLES) begin
      errors++;
      $display("FAIL preempt_len: got ch1=%0d ch2=%0d, expected %0d each", ch1_shown, ch2_shown, HOLD_CYCLES);
    end
  endtask

  task automatic test_simultaneous();
    msg_digits = {16'h2222, 16'h3333};
    msg_valid = 2'b11;
    step();
    msg_valid = 2'b00;
    checks++;
    if (msg_ready !== 2'b00) begin
      errors++;
      $display("FAIL simul_ready: got %b, expected 00", msg_ready);
    end
    for (int c = 0; c < 13; c++) begin
      step();
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL simul cyc=%0d: got %h, expected %h", c, obs, expected());
      end
    end
  endtask

  task automatic test_cancel();
    msg_digits = {16'h4444, 16'h5555};
    msg_valid = 2'b11;
    step();
    msg_valid = 2'b00;
    step();
    msg_cancel = 2'b10;
    step();
    msg_cancel = 2'b00;
    step();
    checks++;
    if (active_src !== 2'd1 || {in4, in3, in2, in1} !== 16'h5555) begin
      errors++;
      $display("FAIL cancel_switch: got src=%0d digits=%h, expected src=1 digits=5555",
               active_src, {in4, in3, in2, in1});
    end
    for (int c = 0; c < 8; c++) step();
    msg_cancel = 2'b11;           // both slots empty now
    step();
    msg_cancel = 2'b00;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs !== expected() || msg_ready !== 2'b11) begin
        errors++;
        $display("FAIL cancel_empty cyc=%0d: got %h, expected %h", c, obs, expected());
      end
    end
  endtask

  task automatic test_blink();
    base_blink = 4'b0001;
    base_dp = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (obs !== expected() || {in4, in3, in2} !== 12'h123) begin
        errors++;
        $display("FAIL blink cyc=%0d: got %h, expected %h", c, obs, expected());
      end
    end
    base_blink = 4'b0000;
    base_dp = 4'b0000;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      msg_valid   = 2'($urandom_range(0, 3));
      msg_cancel  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      msg_digits  = $urandom;
      msg_dp      = 8'($urandom);
      msg_blink   = 8'($urandom);
      base_digits = 16'($urandom);
      base_dp     = 4'($urandom);
      base_blink  = 4'($urandom);
      step();
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL random cyc=%0d: got %h, expected %h", c, obs, expected());
      end
    end
    msg_valid = 2'b00; msg_cancel = 2'b00; msg_blink = 8'h0;
    base_digits = 16'h1234; base_dp = 4'h0; base_blink = 4'h0;
    for (int c = 0; c < 12; c++) step();
  endtask

  task automatic test_reset_mid();
    msg_digits[15:0] = 16'h9876;
    msg_valid = 2'b01;
    step();
    msg_valid = 2'b00;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== {16'hFFFF, 4'h0, 2'd0, 2'b11}) begin
      errors++;
      $display("FAIL reset_async: got %h, expected %h", obs, {16'hFFFF, 4'h0, 2'd0, 2'b11});
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (obs !== expected() || active_src !== 2'd0) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d: got %h, expected %h", c, obs, expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_simultaneous();
    test_cancel();
    test_blink();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tube_display_sched.md
# tube_display_sched

Scheduler that shares the 4-digit tube display between one always-present base source and two timed message channels. It drives the digit codes and decimal points of the tube display driver (`in1`..`in4`, `dp`). Message channel 2 preempts channel 1, and channel 1 preempts the base. Each accepted message is shown for a fixed number of displayed cycles, with optional per-digit blinking.

## Interface
Parameters:
- `HOLD_W`, default 28: width of each message hold timer.
- `HOLD_CYCLES`, default 100_000_000: number of displayed cycles per message; valid range 1..2^HOLD_W-1.
- `BLINK_W`, default 24: width of the free-running blink counter; its MSB is the blink phase.
- `BLANK_CODE`, default 4'hF: digit code the tube decoder renders dark.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `base_digits`  in  16  base digits; [3:0]→`in1`, [7:4]→`in2`, [11:8]→`in3`, [15:12]→`in4`.
- `base_dp`  in  4  base decimal points; bit i→`dp[i]`.
- `base_blink`  in  4  per-digit blink enable for the base.
- `msg_valid`  in  2  per-channel request; index k = channel k+1.
- `msg_ready`  out  2  per-channel slot empty.
- `msg_digits`  in  2×16  per-channel digits, same mapping as `base_digits`.
- `msg_dp`  in  2×4  per-channel decimal points.
- `msg_blink`  in  2×4  per-channel blink enables.
- `msg_cancel`  in  2  per-channel cancel.
- `in1`, `in2`, `in3`, `in4`  out  4 each  digit codes to the display driver, registered.
- `dp`  out  4  decimal points to the display driver, registered.
- `active_src`  out  2  source currently on the outputs: 0 base, 1 ch1, 2 ch2; registered.

## Operation
- Each channel has a one-entry slot holding digits, dp, blink, a full flag and a hold timer.
- `msg_ready[k]` = ~full[k], driven combinationally from the register.
- Accept: `msg_valid[k] & msg_ready[k]` at an edge. The slot captures the payload, sets full, and loads the timer with HOLD_CYCLES-1.
- Selection, each cycle, from slot state: full[1] → ch2; else full[0] → ch1; else base.
- Only the selected channel's timer decrements. A preempted ch1 pauses and resumes with its remaining count.
- When the selected channel's timer is 0, the slot clears at that edge. It has then been displayed exactly HOLD_CYCLES cycles.
- `msg_cancel[k]` with full[k] clears the slot at the next edge. Cancel of an empty slot is ignored. Cancel has priority over expiry.
- Blink: free-running counter of BLINK_W bits; phase = MSB. When phase=1, every digit whose selected blink bit is set outputs BLANK_CODE and its dp outputs 0.
- Output registers load from the selected source after blink masking.

## Timing
- Reset values:
  - `in1`..`in4` = BLANK_CODE, `dp` = 0, `active_src` = 0.
  - Slots empty, so `msg_ready` = 2'b11.
  - Timers and blink counter = 0.
- Acceptance at edge t:
  - `msg_ready[k]` is low from t.
  - The outputs show the message, and `active_src` changes, from edge t+1 (1-cycle latency).
- Expiry at edge e: base or the lower channel appears on the outputs at e+1, and `msg_ready[k]` rises at e.
- Simultaneous accept on both channels: both slots fill; ch2 is displayed first, then ch1 for its full HOLD_CYCLES.
- Ch2 arrives in the same cycle ch1 expires: ch1 still clears, because it was the selected channel that cycle.
- Re-accept on the same channel is possible in the cycle after its slot clears; there are no back-to-back gaps beyond that cycle.
- Reset asserted mid-message: all state returns to reset values immediately and asynchronously; the pending message is lost.
- Timer arithmetic: unsigned HOLD_W, with no wrap, since decrement happens only when nonzero and expiry is checked at 0.

## Test plan
- Reset with `base_digits`=16'h1234 and no messages:
  - During reset, outputs are BLANK_CODE with `dp`=0.
  - From the second edge after release: `in1`=4, `in2`=3, `in3`=2, `in4`=1, `active_src`=0, and `msg_ready`=2'b11.
- HOLD_CYCLES=5; ch1 accepts 16'h5678 at edge t:
  - Outputs show 8,7,6,5 for exactly 5 cycles starting at t+1, then return to base.
  - `msg_ready[0]` is low for t..t+4.
- Preemption: ch1 accepted; after 2 displayed cycles ch2 is accepted with HOLD_CYCLES=5:
  - ch2 is shown 5 cycles, then ch1 is shown for its remaining 3 cycles.
- Simultaneous accept of both channels in one cycle:
  - Display shows ch2 for 5 cycles, then ch1 for 5 cycles, then base.
  - Both `msg_ready` bits fall together and rise when each respective slot clears.
- Cancel ch2 mid-display while ch1 is pending:
  - ch1 is displayed from the cycle after the cancel edge.
  - Cancel of an empty slot leaves all state unchanged.
- BLINK_W=3, `base_blink`=4'b0001, `base_dp`=4'b0001:
  - `in1` alternates between its digit and BLANK_CODE every 4 cycles, with `dp[0]` masked in step.
  - `in2`..`in4` stay steady.
